// File: rtl/lru_victim_ctrl_if.sv
// Access/fill/flush handshake between the cache FSM and the LRU victim controller.
//   master modport: cache FSM side (drives requests, fill completion, flush start)
//   slave modport : lru_victim_ctrl side (drives ready, fill request, response, flush done)
//   req_valid/req_ready/req_index, hit0/hit1, valid0/valid1 : access request
//   fill_req/fill_way/fill_done                            : miss fill handshake
//   done/resp_way/resp_miss/resp_err                       : access response
//   flush_req/flush_done                                   : full-array flush
interface lru_victim_ctrl_if #(
  parameter int unsigned IDX_W = 6
);
  logic             req_valid;
  logic             req_ready;
  logic [IDX_W-1:0] req_index;
  logic             hit0;
  logic             hit1;
  logic             valid0;
  logic             valid1;
  logic             flush_req;
  logic             fill_req;
  logic             fill_way;
  logic             fill_done;
  logic             done;
  logic             resp_way;
  logic             resp_miss;
  logic             resp_err;
  logic             flush_done;

  modport master (
    output req_valid, req_index, hit0, hit1, valid0, valid1, flush_req, fill_done,
    input  req_ready, fill_req, fill_way, done, resp_way, resp_miss, resp_err, flush_done
  );

  modport slave (
    input  req_valid, req_index, hit0, hit1, valid0, valid1, flush_req, fill_done,
    output req_ready, fill_req, fill_way, done, resp_way, resp_miss, resp_err, flush_done
  );
endinterface

// File: rtl/lru_victim_ctrl.sv
// Per-set replacement controller for a 2-way set-associative cache. Owns the
// read/modify/write of the 1-bit-per-set LRU register file: looks up the set's
// LRU bit, picks the victim on a miss, sequences the fill, writes back the
// updated bit. Also sweeps the whole LRU file to FLUSH_VAL on request.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   bus (slave)  : request / fill / response / flush handshake
//   lru_addr     : LRU file address (0 while idle)
//   lru_rd_data  : LRU file read data, combinational from lru_addr
//   lru_wr_data  : LRU file write data
//   lru_wr_en    : LRU file write enable (UPDATE and FLUSH only)
// LRU bit meaning: the way to evict next; after an access to way w it becomes ~w.
module lru_victim_ctrl #(
  parameter int unsigned IDX_W     = 6,
  parameter logic        FLUSH_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  lru_victim_ctrl_if.slave bus,
  output logic [IDX_W-1:0] lru_addr,
  input  logic             lru_rd_data,
  output logic             lru_wr_data,
  output logic             lru_wr_en
);

  localparam int unsigned SETS = 2 ** IDX_W;
  // One extra counter bit so the last-entry compare never aliases with a wrap.
  localparam logic [IDX_W:0] LastCnt = (IDX_W+1)'(SETS - 1);

  typedef enum logic [2:0] {StIdle, StLookup, StFill, StUpdate, StFlush} state_e;

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             hit0_q, hit1_q, valid0_q, valid1_q;
  logic             way_q;
  logic [IDX_W:0]   cnt_q;
  logic [IDX_W:0]   cnt_nxt;

  logic             req_ready_q, fill_req_q, fill_way_q, done_q;
  logic             resp_way_q, resp_miss_q, resp_err_q, flush_done_q;
  logic [IDX_W-1:0] lru_addr_q;
  logic             lru_wr_data_q, lru_wr_en_q;

  logic hit, hit_way, victim;

  assign cnt_nxt = cnt_q + 1'b1;

  // Lookup decision; lru_addr already points at idx_q while in StLookup.
  always_comb begin
    hit     = hit0_q | hit1_q;
    hit_way = ~hit0_q;  // double hit resolves to way 0
    if (!valid0_q) begin
      victim = 1'b0;
    end else if (!valid1_q) begin
      victim = 1'b1;
    end else begin
      victim = lru_rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      hit0_q        <= 1'b0;
      hit1_q        <= 1'b0;
      valid0_q      <= 1'b0;
      valid1_q      <= 1'b0;
      way_q         <= 1'b0;
      cnt_q         <= '0;
      req_ready_q   <= 1'b1;
      fill_req_q    <= 1'b0;
      fill_way_q    <= 1'b0;
      done_q        <= 1'b0;
      resp_way_q    <= 1'b0;
      resp_miss_q   <= 1'b0;
      resp_err_q    <= 1'b0;
      flush_done_q  <= 1'b0;
      lru_addr_q    <= '0;
      lru_wr_data_q <= 1'b0;
      lru_wr_en_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.flush_req) begin
            state_q       <= StFlush;
            cnt_q         <= '0;
            req_ready_q   <= 1'b0;
            lru_addr_q    <= '0;
            lru_wr_en_q   <= 1'b1;
            lru_wr_data_q <= FLUSH_VAL;
            flush_done_q  <= (LastCnt == '0);
          end else if (bus.req_valid) begin
            state_q     <= StLookup;
            idx_q       <= bus.req_index;
            hit0_q      <= bus.hit0;
            hit1_q      <= bus.hit1;
            valid0_q    <= bus.valid0;
            valid1_q    <= bus.valid1;
            req_ready_q <= 1'b0;
            lru_addr_q  <= bus.req_index;
          end
        end
        StLookup: begin
          if (hit) begin
            state_q       <= StUpdate;
            way_q         <= hit_way;
            lru_wr_en_q   <= 1'b1;
            lru_wr_data_q <= ~hit_way;
            done_q        <= 1'b1;
            resp_way_q    <= hit_way;
            resp_miss_q   <= 1'b0;
            resp_err_q    <= hit0_q & hit1_q;
          end else begin
            state_q    <= StFill;
            way_q      <= victim;
            fill_req_q <= 1'b1;
            fill_way_q <= victim;
          end
        end
        StFill: begin
          if (bus.fill_done) begin
            state_q       <= StUpdate;
            fill_req_q    <= 1'b0;
            lru_wr_en_q   <= 1'b1;
            lru_wr_data_q <= ~way_q;
            done_q        <= 1'b1;
            resp_way_q    <= way_q;
            resp_miss_q   <= 1'b1;
            resp_err_q    <= 1'b0;
          end
        end
        StUpdate: begin
          state_q       <= StIdle;
          lru_wr_en_q   <= 1'b0;
          lru_wr_data_q <= 1'b0;
          lru_addr_q    <= '0;
          fill_way_q    <= 1'b0;
          done_q        <= 1'b0;
          resp_way_q    <= 1'b0;
          resp_miss_q   <= 1'b0;
          resp_err_q    <= 1'b0;
          req_ready_q   <= 1'b1;
        end
        StFlush: begin
          if (cnt_q == LastCnt) begin
            state_q       <= StIdle;
            lru_wr_en_q   <= 1'b0;
            lru_wr_data_q <= 1'b0;
            lru_addr_q    <= '0;
            flush_done_q  <= 1'b0;
            req_ready_q   <= 1'b1;
          end else begin
            cnt_q        <= cnt_nxt;
            lru_addr_q   <= cnt_nxt[IDX_W-1:0];
            flush_done_q <= (cnt_nxt == LastCnt);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.fill_req   = fill_req_q;
  assign bus.fill_way   = fill_way_q;
  assign bus.done       = done_q;
  assign bus.resp_way   = resp_way_q;
  assign bus.resp_miss  = resp_miss_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.flush_done = flush_done_q;
  assign lru_addr       = lru_addr_q;
  assign lru_wr_data    = lru_wr_data_q;
  assign lru_wr_en      = lru_wr_en_q;

endmodule

// File: tb/tb_lru_victim_ctrl.sv
// Bench for lru_victim_ctrl: reset state, full flush sweep, a table of directed
// accesses, back-to-back and reset-during-fill sequences, then random accesses
// checked against an array model of the per-set LRU bits.
module tb_lru_victim_ctrl;
  localparam int unsigned IdxW = 6;
  localparam int unsigned Sets = 64;

  logic clk = 1'b0;
  logic rst;

  lru_victim_ctrl_if #(.IDX_W(IdxW)) bus ();

  logic [IdxW-1:0] lru_addr;
  logic            lru_rd_data;
  logic            lru_wr_data;
  logic            lru_wr_en;

  lru_victim_ctrl #(.IDX_W(IdxW), .FLUSH_VAL(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .lru_addr   (lru_addr),
    .lru_rd_data(lru_rd_data),
    .lru_wr_data(lru_wr_data),
    .lru_wr_en  (lru_wr_en)
  );

  always #5 clk = ~clk;

  // LRU register file; pre_* is a bench-side preload port used only while idle.
  logic            lru_mem [Sets];
  int unsigned     wr_cnt;
  logic            pre_en;
  logic [IdxW-1:0] pre_addr;
  logic            pre_val;

  assign lru_rd_data = lru_mem[lru_addr];

  always @(posedge clk) begin
    if (lru_wr_en) begin
      lru_mem[lru_addr] <= lru_wr_data;
      wr_cnt            <= wr_cnt + 1;
    end else if (pre_en) begin
      lru_mem[pre_addr] <= pre_val;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic quiet_inputs();
    bus.req_valid = 1'b0;
    bus.req_index = '0;
    bus.hit0      = 1'b0;
    bus.hit1      = 1'b0;
    bus.valid0    = 1'b0;
    bus.valid1    = 1'b0;
    bus.flush_req = 1'b0;
    bus.fill_done = 1'b0;
  endtask

  task automatic preset(input logic [IdxW-1:0] a, input logic v);
    pre_en   = 1'b1;
    pre_addr = a;
    pre_val  = v;
    @(negedge clk);
    pre_en   = 1'b0;
  endtask

  // Starts and ends at a negedge with the DUT idle. req_valid may already be high.
  task automatic do_flush();
    int unsigned wr0;
    int          bad;
    wr0 = wr_cnt;
    bus.flush_req = 1'b1;
    @(negedge clk);
    bus.flush_req = 1'b0;
    for (int k = 0; k < Sets; k++) begin
      check("flush_beat", {lru_wr_en, lru_addr, lru_wr_data, bus.flush_done, bus.req_ready},
            {1'b1, IdxW'(k), 1'b0, (k == Sets - 1), 1'b0});
      @(negedge clk);
    end
    check("flush_end", {bus.req_ready, bus.flush_done, lru_wr_en}, 3'b100);
    check("flush_wr_cnt", wr_cnt - wr0, Sets);
    bad = 0;
    for (int k = 0; k < Sets; k++) if (lru_mem[k] !== 1'b0) bad++;
    check("flush_all_zero", bad, 0);
  endtask

  // One access; starts and ends at a negedge with the DUT idle.
  task automatic do_access(input logic [IdxW-1:0] idx, input logic h0, input logic h1,
                           input logic v0, input logic v1, input int fd,
                           input logic e_way, input logic e_miss, input logic e_err,
                           input logic e_lru, input bit noise);
    int          c;
    int          fcnt;
    bit          seen_done;
    int unsigned wr0;
    check("req_ready_idle", bus.req_ready, 1);
    wr0 = wr_cnt;
    bus.req_valid = 1'b1;
    bus.req_index = idx;
    bus.hit0      = h0;
    bus.hit1      = h1;
    bus.valid0    = v0;
    bus.valid1    = v1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    c = 1;
    fcnt = 0;
    seen_done = 0;
    while (!seen_done && c < 40) begin
      if (c == 1) check("ready_busy", bus.req_ready, 0);
      if (bus.fill_req) begin
        fcnt++;
        check("fill_way", bus.fill_way, e_way);
      end
      if (bus.done) begin
        seen_done = 1;
        check("done_cycle", c, e_miss ? 3 + fd : 2);
        check("resp", {bus.resp_way, bus.resp_miss, bus.resp_err}, {e_way, e_miss, e_err});
        check("lru_wr_beat", {lru_wr_en, lru_addr, lru_wr_data}, {1'b1, idx, ~e_way});
        check("fill_cycles", fcnt, e_miss ? fd + 1 : 0);
        bus.fill_done = 1'b0;
        bus.flush_req = 1'b0;
      end else begin
        if (bus.fill_req) bus.fill_done = (fcnt == fd + 1);
        else              bus.fill_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.flush_req = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
        c++;
      end
    end
    if (!seen_done) begin
      check("done_timeout", 0, 1);
      quiet_inputs();
      @(negedge clk);
    end else begin
      @(negedge clk);
      check("ready_after", bus.req_ready, 1);
      check("addr_idle", {lru_addr, lru_wr_en}, 0);
      check("wr_count", wr_cnt - wr0, 1);
      check("lru_final", lru_mem[idx], e_lru);
    end
  endtask

  typedef struct {
    logic [IdxW-1:0] idx;
    logic            h0, h1, v0, v1, pre;
    int              fd;
    logic            e_way, e_miss, e_err, e_lru;
  } vec_t;

  vec_t vt [8];
  logic lru_ref [Sets];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [IdxW-1:0] idx;
    logic            h0, h1, v0, v1, way, miss;
    int              fd, kind;

    //            idx    h0    h1    v0    v1    pre  fd  way   miss  err   lru
    vt[0] = '{6'd5,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[1] = '{6'd9,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[2] = '{6'd2,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[3] = '{6'd7,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[4] = '{6'd0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[5] = '{6'd63, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[6] = '{6'd33, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[7] = '{6'd9,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1};

    pre_en = 1'b0;
    pre_addr = '0;
    pre_val = 1'b0;
    quiet_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs",
          {bus.req_ready, bus.done, bus.fill_req, bus.fill_way, bus.resp_way, bus.resp_miss,
           bus.resp_err, bus.flush_done, lru_wr_en, lru_wr_data, lru_addr},
          {1'b1, 9'b0, 6'd0});
    rst = 1'b0;
    @(negedge clk);

    // Flush with a request pending: flush wins, request is accepted afterwards.
    bus.req_valid = 1'b1;
    bus.req_index = 6'd5;
    bus.hit0      = 1'b1;
    bus.valid0    = 1'b1;
    bus.valid1    = 1'b1;
    do_flush();
    check("req_pending_after_flush", {bus.req_ready, bus.req_valid}, 2'b11);
    do_access(6'd5, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 0);

    for (int i = 0; i < 8; i++) begin
      preset(vt[i].idx, vt[i].pre);
      do_access(vt[i].idx, vt[i].h0, vt[i].h1, vt[i].v0, vt[i].v1, vt[i].fd,
                vt[i].e_way, vt[i].e_miss, vt[i].e_err, vt[i].e_lru, 0);
    end

    // Back-to-back misses on one set must see each other's update.
    preset(6'd12, 1'b0);
    do_access(6'd12, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 0);
    do_access(6'd12, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b0, 1'b0, 0);

    // Reset while a fill is outstanding: abandoned with no LRU write.
    begin
      int unsigned wr0;
      preset(6'd20, 1'b1);
      wr0 = wr_cnt;
      bus.req_valid = 1'b1;
      bus.req_index = 6'd20;
      bus.hit0 = 1'b0;
      bus.hit1 = 1'b0;
      bus.valid0 = 1'b1;
      bus.valid1 = 1'b1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      check("rst_fill_started", {bus.fill_req, bus.fill_way}, 2'b11);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_in_fill", {bus.fill_req, bus.req_ready, bus.done, lru_wr_en}, 4'b0100);
      rst = 1'b0;
      @(negedge clk);
      check("rst_fill_no_write", wr_cnt - wr0, 0);
      check("rst_fill_lru_kept", lru_mem[20], 1'b1);
    end

    // Random accesses against the array model.
    quiet_inputs();
    for (int n = 0; n < 150; n++) begin
      if (n % 60 == 0) begin
        do_flush();
        for (int k = 0; k < Sets; k++) lru_ref[k] = 1'b0;
      end
      idx  = ($urandom_range(0, 4) == 0) ? IdxW'($urandom_range(0, Sets - 1))
                                         : IdxW'($urandom_range(0, 7));
      kind = $urandom_range(0, 3);
      h0   = (kind == 0) || (kind == 2);
      h1   = (kind == 1) || (kind == 2);
      v0   = ($urandom_range(0, 3) != 0);
      v1   = ($urandom_range(0, 3) != 0);
      fd   = $urandom_range(0, 4);
      miss = !(h0 || h1);
      if (h0)       way = 1'b0;
      else if (h1)  way = 1'b1;
      else if (!v0) way = 1'b0;
      else if (!v1) way = 1'b1;
      else          way = lru_ref[idx];
      lru_ref[idx] = !way;
      do_access(idx, h0, h1, v0, v1, fd, way, miss, h0 && h1, lru_ref[idx], 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
